// File: rtl/upload_buffer.sv
// rtl/upload_buffer.sv - CPU-filled byte buffer served back to the HPS over the ioctl upload channel.
module upload_buffer #(
  parameter int         ADDR_WIDTH   = 10,
  parameter logic [7:0] UPLOAD_INDEX = 8'd2
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  cpu_buf_cs,
  input  logic                  cpu_reg_cs,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_wr_n,
  input  logic [7:0]            cpu_dout,
  output logic [7:0]            cpu_din,
  output logic                  upload_req,
  input  logic                  ioctl_upload,
  input  logic [7:0]            ioctl_index,
  input  logic                  ioctl_rd,
  input  logic [ADDR_WIDTH-1:0] ioctl_addr,
  output logic [7:0]            ioctl_din
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int LW    = ADDR_WIDTH + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;
  state_t state, state_next;

  logic [7:0]    mem [DEPTH];
  logic [7:0]    ram_a_q, ram_b_q, reg_q, reg_rd;
  logic          buf_sel_q, hit_q;
  logic [LW-1:0] len, lenq, cnt;
  logic [15:0]   len16, cnt16;
  logic          done, err, busy;
  logic          reg_wr, buf_wr, start, abort, idx_ok, rd_live, in_range;

  assign busy     = (state != IDLE);
  assign reg_wr   = cpu_reg_cs && !cpu_wr_n;
  assign buf_wr   = cpu_buf_cs && !cpu_wr_n;
  assign start    = reg_wr && (cpu_addr[2:0] == 3'd0) && cpu_dout[0];
  assign abort    = reg_wr && (cpu_addr[2:0] == 3'd0) && cpu_dout[1];
  assign idx_ok   = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
  assign rd_live  = (state == XFER) && idx_ok;
  assign in_range = ({1'b0, ioctl_addr} < lenq);
  assign len16    = 16'(len);
  assign cnt16    = 16'(cnt);

  assign upload_req = (state == REQ);
  assign cpu_din    = buf_sel_q ? ram_a_q : reg_q;
  assign ioctl_din  = hit_q ? ram_b_q : 8'h00;

  // Port A: CPU, writes blocked while a transfer is armed or running.
  always_ff @(posedge clk_sys) begin
    if (buf_wr && !busy) mem[cpu_addr] <= cpu_dout;
    ram_a_q <= mem[cpu_addr];
  end

  // Port B: HPS, the read register only moves on a strobe so the byte holds between strobes.
  always_ff @(posedge clk_sys) begin
    if (ioctl_rd) ram_b_q <= mem[ioctl_addr];
  end

  always_comb begin
    reg_rd = 8'h00;
    case (cpu_addr[2:0])
      3'd0:    reg_rd = {5'b0, err, done, busy};
      3'd1:    reg_rd = len16[7:0];
      3'd2:    reg_rd = len16[15:8];
      3'd3:    reg_rd = cnt16[7:0];
      3'd4:    reg_rd = cnt16[15:8];
      default: reg_rd = 8'h00;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && (len != '0)) state_next = REQ;
      REQ: begin
        if (idx_ok)     state_next = XFER;
        else if (abort) state_next = IDLE;
      end
      XFER:    if (!ioctl_upload) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      len       <= '0;
      lenq      <= '0;
      cnt       <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      reg_q     <= 8'h00;
      buf_sel_q <= 1'b0;
      hit_q     <= 1'b0;
    end else begin
      buf_sel_q <= cpu_buf_cs;
      reg_q     <= cpu_reg_cs ? reg_rd : 8'h00;
      if (buf_wr && busy) err <= 1'b1;
      if (reg_wr && !busy) begin
        if (cpu_addr[2:0] == 3'd1) len <= {len[LW-1:8], cpu_dout};
        if (cpu_addr[2:0] == 3'd2) len <= LW'({cpu_dout, len[7:0]});
      end
      case (state)
        IDLE: begin
          if (start && (len != '0)) begin
            lenq <= (len > DEPTH_L) ? DEPTH_L : len;
            cnt  <= '0;
            done <= 1'b0;
            err  <= 1'b0;
          end else if (start) begin
            done <= 1'b1;
          end
        end
        REQ:     if (state_next == IDLE) err <= 1'b1;
        XFER:    if (state_next == IDLE) done <= 1'b1;
        default: ;
      endcase
      // Range result is registered alongside port B so both describe the same strobe.
      if (ioctl_rd) begin
        hit_q <= rd_live && in_range;
        if (rd_live && in_range && (cnt < lenq)) cnt <= cnt + LW'(1);
      end
    end
  end

endmodule

// File: tb/tb_upload_buffer.sv
// tb/tb_upload_buffer.sv - directed scoreboard bench for upload_buffer.
module tb_upload_buffer;
  localparam int AW = 10;

  logic          clk_sys = 1'b0;
  logic          reset_n, cpu_buf_cs, cpu_reg_cs, cpu_wr_n;
  logic [AW-1:0] cpu_addr, ioctl_addr;
  logic [7:0]    cpu_dout, cpu_din, ioctl_index, ioctl_din;
  logic          upload_req, ioctl_upload, ioctl_rd;

  upload_buffer #(.ADDR_WIDTH(AW), .UPLOAD_INDEX(8'd2)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .cpu_buf_cs(cpu_buf_cs), .cpu_reg_cs(cpu_reg_cs),
    .cpu_addr(cpu_addr), .cpu_wr_n(cpu_wr_n), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
    .upload_req(upload_req), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din)
  );

  always #5 clk_sys = ~clk_sys;

  int total  = 0;
  int passed = 0;
  int failed = 0;
  logic [7:0] exp_q[$];
  string      tag_q[$];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic score(input logic [7:0] obs);
    if (exp_q.size() == 0) check("scoreboard_empty", obs, 8'hxx);
    else check(tag_q.pop_front(), obs, exp_q.pop_front());
  endtask

  task automatic cpu_write(input bit is_reg, input int addr, input logic [7:0] data);
    @(negedge clk_sys);
    cpu_buf_cs = !is_reg; cpu_reg_cs = is_reg; cpu_addr = AW'(addr);
    cpu_dout = data; cpu_wr_n = 1'b0;
    @(negedge clk_sys);
    cpu_buf_cs = 1'b0; cpu_reg_cs = 1'b0; cpu_wr_n = 1'b1;
  endtask

  task automatic cpu_read(input bit is_reg, input int addr, input logic [7:0] exp, input string tag);
    expect_byte(tag, exp);
    @(negedge clk_sys);
    cpu_buf_cs = !is_reg; cpu_reg_cs = is_reg; cpu_addr = AW'(addr); cpu_wr_n = 1'b1;
    @(negedge clk_sys);
    score(cpu_din);
    cpu_buf_cs = 1'b0; cpu_reg_cs = 1'b0;
  endtask

  task automatic hps_read(input int addr, input logic [7:0] exp, input string tag);
    expect_byte(tag, exp);
    @(negedge clk_sys);
    ioctl_rd = 1'b1; ioctl_addr = AW'(addr);
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    score(ioctl_din);
  endtask

  initial begin
    logic [7:0] pat [4];
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
    reset_n = 1'b0; cpu_buf_cs = 1'b0; cpu_reg_cs = 1'b0; cpu_wr_n = 1'b1;
    cpu_addr = '0; cpu_dout = 8'h00; ioctl_upload = 1'b0; ioctl_index = 8'h00;
    ioctl_rd = 1'b0; ioctl_addr = '0;
    repeat (3) @(negedge clk_sys);
    check("rst_upload_req", {7'b0, upload_req}, 8'h00);
    check("rst_cpu_din", cpu_din, 8'h00);
    check("rst_ioctl_din", ioctl_din, 8'h00);
    reset_n = 1'b1;
    cpu_read(1, 0, 8'h00, "rst_status");
    cpu_read(1, 3, 8'h00, "rst_cnt_l");

    // Basic upload of four bytes
    for (int i = 0; i < 4; i++) cpu_write(0, i, pat[i]);
    cpu_read(0, 2, 8'h33, "buf_readback");
    cpu_write(1, 1, 8'h04);
    cpu_write(1, 2, 8'h00);
    cpu_read(1, 1, 8'h04, "len_l");
    cpu_write(1, 0, 8'h01);
    check("start_req", {7'b0, upload_req}, 8'h01);
    cpu_read(1, 0, 8'h01, "status_busy");
    @(negedge clk_sys); ioctl_index = 8'd2; ioctl_upload = 1'b1;
    @(negedge clk_sys);
    check("xfer_req_low", {7'b0, upload_req}, 8'h00);
    for (int a = 0; a < 6; a++) hps_read(a, (a < 4) ? pat[a] : 8'h00, $sformatf("rd_addr%0d", a));
    @(negedge clk_sys); ioctl_upload = 1'b0;
    @(negedge clk_sys);
    cpu_read(1, 0, 8'h02, "status_done");
    cpu_read(1, 3, 8'h04, "cnt_l");
    cpu_read(1, 4, 8'h00, "cnt_h");

    // Zero length start
    cpu_write(1, 1, 8'h00);
    cpu_write(1, 0, 8'h01);
    check("len0_no_req", {7'b0, upload_req}, 8'h00);
    cpu_read(1, 0, 8'h02, "len0_status");

    // Abort while requesting
    cpu_write(1, 1, 8'h08);
    cpu_write(1, 0, 8'h01);
    check("len8_req", {7'b0, upload_req}, 8'h01);
    cpu_write(1, 0, 8'h02);
    check("abort_req_low", {7'b0, upload_req}, 8'h00);
    cpu_read(1, 0, 8'h04, "abort_status");
    @(negedge clk_sys); ioctl_index = 8'd3; ioctl_upload = 1'b1;
    repeat (2) @(negedge clk_sys);
    check("idx3_no_req", {7'b0, upload_req}, 8'h00);
    hps_read(0, 8'h00, "idle_read_zero");
    cpu_read(1, 3, 8'h00, "idle_cnt");
    @(negedge clk_sys); ioctl_upload = 1'b0;

    // START+ABORT together, busy write protection, wrong index in XFER
    cpu_write(1, 1, 8'h04);
    cpu_write(1, 0, 8'h03);
    check("start_wins", {7'b0, upload_req}, 8'h01);
    @(negedge clk_sys); ioctl_index = 8'd3; ioctl_upload = 1'b1;
    repeat (2) @(negedge clk_sys);
    check("req_wrong_idx", {7'b0, upload_req}, 8'h01);
    ioctl_index = 8'd2;
    @(negedge clk_sys);
    check("xfer2_req_low", {7'b0, upload_req}, 8'h00);
    cpu_write(0, 0, 8'hFF);
    cpu_write(1, 1, 8'h03);
    cpu_write(1, 0, 8'h01);
    cpu_write(1, 0, 8'h02);
    check("busy_no_restart", {7'b0, upload_req}, 8'h00);
    hps_read(0, 8'h11, "orig_byte");
    ioctl_index = 8'd3;
    hps_read(1, 8'h00, "xfer_wrong_idx");
    ioctl_index = 8'd2;
    cpu_read(1, 0, 8'h05, "status_busy_err");
    @(negedge clk_sys); ioctl_upload = 1'b0;
    @(negedge clk_sys);
    cpu_read(1, 0, 8'h06, "status_done_err");
    cpu_read(1, 3, 8'h01, "cnt_one");
    cpu_read(1, 1, 8'h04, "len_kept");
    cpu_read(0, 0, 8'h11, "buf_unchanged");

    // Oversized length, then reset mid transfer
    cpu_write(0, 1023, 8'h5A);
    cpu_write(1, 1, 8'hD0);
    cpu_write(1, 2, 8'h07);
    cpu_read(1, 2, 8'h07, "len_h");
    cpu_write(1, 0, 8'h01);
    @(negedge clk_sys); ioctl_upload = 1'b1;
    @(negedge clk_sys);
    hps_read(1023, 8'h5A, "rd_top");
    hps_read(3, 8'h44, "rd_addr3_again");
    cpu_read(1, 3, 8'h02, "cnt_two");
    cpu_read(1, 5, 8'h00, "reg5_zero");
    @(negedge clk_sys); reset_n = 1'b0;
    @(negedge clk_sys);
    check("midrst_req", {7'b0, upload_req}, 8'h00);
    check("midrst_ioctl_din", ioctl_din, 8'h00);
    reset_n = 1'b1; ioctl_upload = 1'b0;
    cpu_read(1, 0, 8'h00, "midrst_status");
    cpu_read(1, 3, 8'h00, "midrst_cnt");
    cpu_read(1, 1, 8'h00, "midrst_len");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
